// File: rtl/lp805x_clksel_ctrl_if.sv
// Bundle of request, lock and mux-control signals between software/PLL side and the clock sequencer.
// master drives requests and the raw PLL lock; slave (the sequencer) drives the mux controls and status.
// Pure wiring, no state.
interface lp805x_clksel_ctrl_if;
  logic       wr;
  logic [1:0] wr_data;
  logic       locked_in;
  logic       lost_clr;
  logic [1:0] select;
  logic       clk_ena;
  logic       busy;
  logic [1:0] req;
  logic       lock_ok;
  logic       lock_lost;

  modport master (
    output wr, wr_data, locked_in, lost_clr,
    input  select, clk_ena, busy, req, lock_ok, lock_lost
  );

  modport slave (
    input  wr, wr_data, locked_in, lost_clr,
    output select, clk_ena, busy, req, lock_ok, lock_lost
  );
endinterface

// File: rtl/lp805x_clksel_ctrl.sv
// Glitch-safe clock-source sequencer driving the clkctrl mux select and enable, with PLL lock qualification.
// Latency: select changes GATE_CYC+2 edges after the deciding edge, clk_ena returns at 2*GATE_CYC+2.
// No back-pressure: requests are latched on every write, last write wins, busy is status only.
module lp805x_clksel_ctrl #(
  parameter int LOCK_STABLE = 16,
  parameter int GATE_CYC    = 4,
  parameter int CNT_W       = 8
) (
  input logic                 clk,
  input logic                 rst,
  lp805x_clksel_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] LOCK_MAX  = CNT_W'(LOCK_STABLE);
  localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    GATE_OFF = 2'd1,
    SWITCH   = 2'd2,
    GATE_ON  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] lcnt;
  logic [CNT_W-1:0] gcnt;
  logic [CNT_W-1:0] gcnt_nxt;
  logic [1:0]       req;
  logic [1:0]       sel;
  logic [1:0]       sel_nxt;
  logic [1:0]       target;
  logic             ena;
  logic             ena_nxt;
  logic             lock_ok;
  logic             lost;
  logic             lost_set;

  // Lock tracker: two-flop synchronizer, then a saturating run-length counter of locked samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      lcnt  <= '0;
    end else begin
      sync1 <= bus.locked_in;
      sync2 <= sync1;
      if (!sync2) begin
        lcnt <= '0;
      end else if (lcnt != LOCK_MAX) begin
        lcnt <= lcnt + CNT_ONE;
      end
    end
  end

  assign lock_ok = (lcnt == LOCK_MAX);

  // The edge where lock_ok drops is the one where the counter clears while saturated.
  assign lost_set = lock_ok & ~sync2 & sel[1];

  // Request latch and sticky lock-loss flag; a simultaneous set beats the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      req  <= 2'd0;
      lost <= 1'b0;
    end else begin
      if (bus.wr) begin
        req <= bus.wr_data;
      end
      if (lost_set) begin
        lost <= 1'b1;
      end else if (bus.lost_clr) begin
        lost <= 1'b0;
      end
    end
  end

  // PLL sources are only allowed while lock is debounced-good; otherwise fall back to raw inclk0.
  assign target = (req[1] && !lock_ok) ? 2'd0 : req;

  // Sequencer state, mux select, enable and gate timer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      sel   <= 2'd0;
      ena   <= 1'b1;
      gcnt  <= '0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      ena   <= ena_nxt;
      gcnt  <= gcnt_nxt;
    end
  end

  // Next-state: gate the mux off, hold, swap select (re-reading target), hold, re-enable.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    ena_nxt   = ena;
    gcnt_nxt  = gcnt;
    case (state)
      RUN: begin
        if (target != sel) begin
          state_nxt = GATE_OFF;
          ena_nxt   = 1'b0;
          gcnt_nxt  = '0;
        end
      end
      GATE_OFF: begin
        if (gcnt == GATE_LAST) begin
          state_nxt = SWITCH;
        end else begin
          gcnt_nxt = gcnt + CNT_ONE;
        end
      end
      SWITCH: begin
        sel_nxt   = target;
        gcnt_nxt  = '0;
        state_nxt = GATE_ON;
      end
      GATE_ON: begin
        if (gcnt == GATE_LAST) begin
          ena_nxt   = 1'b1;
          state_nxt = RUN;
        end else begin
          gcnt_nxt = gcnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  assign bus.select    = sel;
  assign bus.clk_ena   = ena;
  assign bus.busy      = (state != RUN);
  assign bus.req       = req;
  assign bus.lock_ok   = lock_ok;
  assign bus.lock_lost = lost;

endmodule

// File: tb/tb_lp805x_clksel_ctrl.sv
// Self-checking bench for lp805x_clksel_ctrl: directed scenarios plus a randomized phase.
// Every cycle the DUT is compared with a timeline-style reference model; directed steps add fixed-value checks.
// The bench drives inputs #1 after each rising edge and samples outputs at the same point.
module tb_lp805x_clksel_ctrl;

  localparam int LS = 16;
  localparam int G  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  lp805x_clksel_ctrl_if bus();

  lp805x_clksel_ctrl #(
    .LOCK_STABLE(LS),
    .GATE_CYC   (G),
    .CNT_W      (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: lock_ok is "the last LS synchronized samples were all 1";
  // a switch sequence is a timeline anchored at its start edge.
  int         cyc = 0;
  int         m_t0 = 0;
  bit         m_act = 1'b0;
  logic [1:0] m_sel = 2'd0;
  logic [1:0] m_req = 2'd0;
  logic       m_ena = 1'b1;
  logic       m_lock_ok = 1'b0;
  logic       m_lost = 1'b0;
  bit         hist[$];

  always @(posedge clk) begin
    logic [1:0] tgt;
    logic [1:0] old_sel;
    logic       old_lock;
    logic       new_lock;
    cyc++;
    if (rst) begin
      m_act = 1'b0;
      m_sel = 2'd0;
      m_req = 2'd0;
      m_ena = 1'b1;
      m_lock_ok = 1'b0;
      m_lost = 1'b0;
      hist.delete();
    end else begin
      tgt = (m_req[1] && !m_lock_ok) ? 2'd0 : m_req;
      old_sel = m_sel;
      old_lock = m_lock_ok;
      if (!m_act) begin
        if (tgt != m_sel) begin
          m_act = 1'b1;
          m_t0 = cyc;
          m_ena = 1'b0;
        end
      end else begin
        if (cyc - m_t0 == G + 1) m_sel = tgt;
        if (cyc - m_t0 == 2 * G + 1) begin
          m_ena = 1'b1;
          m_act = 1'b0;
        end
      end
      if (bus.wr) m_req = bus.wr_data;
      hist.push_front(bus.locked_in);
      if (hist.size() > LS + 2) void'(hist.pop_back());
      new_lock = (hist.size() == LS + 2);
      if (new_lock) begin
        for (int i = 2; i < LS + 2; i++) begin
          if (!hist[i]) new_lock = 1'b0;
        end
      end
      if (old_lock && !new_lock && old_sel[1]) m_lost = 1'b1;
      else if (bus.lost_clr) m_lost = 1'b0;
      m_lock_ok = new_lock;
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("mdl_select",    {6'd0, bus.select},    {6'd0, m_sel});
      chk("mdl_clk_ena",   {7'd0, bus.clk_ena},   {7'd0, m_ena});
      chk("mdl_busy",      {7'd0, bus.busy},      {7'd0, m_act});
      chk("mdl_req",       {6'd0, bus.req},       {6'd0, m_req});
      chk("mdl_lock_ok",   {7'd0, bus.lock_ok},   {7'd0, m_lock_ok});
      chk("mdl_lock_lost", {7'd0, bus.lock_lost}, {7'd0, m_lost});
    end
  endtask

  task automatic write(input logic [1:0] v);
    bus.wr = 1'b1;
    bus.wr_data = v;
    tick(1);
    bus.wr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    int run;
    bus.wr = 1'b0;
    bus.wr_data = 2'd0;
    bus.locked_in = 1'b0;
    bus.lost_clr = 1'b0;

    // Reset values
    tick(2);
    chk("rst_select",    {6'd0, bus.select},    8'd0);
    chk("rst_clk_ena",   {7'd0, bus.clk_ena},   8'd1);
    chk("rst_busy",      {7'd0, bus.busy},      8'd0);
    chk("rst_req",       {6'd0, bus.req},       8'd0);
    chk("rst_lock_ok",   {7'd0, bus.lock_ok},   8'd0);
    chk("rst_lock_lost", {7'd0, bus.lock_lost}, 8'd0);
    rst = 1'b0;

    // Plain switch to select 1 without lock
    write(2'd1);
    chk("s1_req", {6'd0, bus.req}, 8'd1);
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      chk("s1_select",  {6'd0, bus.select},  (k >= 6) ? 8'd1 : 8'd0);
      chk("s1_clk_ena", {7'd0, bus.clk_ena}, (k >= 10) ? 8'd1 : 8'd0);
      chk("s1_busy",    {7'd0, bus.busy},    (k < 10) ? 8'd1 : 8'd0);
    end

    // PLL request without lock: no sequence
    do_reset();
    write(2'd2);
    for (int k = 1; k <= 3; k++) begin
      tick(1);
      chk("s2_nolock_select", {6'd0, bus.select}, 8'd0);
      chk("s2_nolock_busy",   {7'd0, bus.busy},   8'd0);
    end

    // Short lock glitch never qualifies
    bus.locked_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      chk("s3_lock_ok", {7'd0, bus.lock_ok}, 8'd0);
    end
    bus.locked_in = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      chk("s3_lock_ok_tail", {7'd0, bus.lock_ok}, 8'd0);
      chk("s3_select",       {6'd0, bus.select},  8'd0);
    end

    // Lock acquired: pending request for 2 proceeds
    bus.locked_in = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      chk("s2_lock_ok", {7'd0, bus.lock_ok}, (k >= 18) ? 8'd1 : 8'd0);
      chk("s2_select",  {6'd0, bus.select},  (k >= 24) ? 8'd2 : 8'd0);
      chk("s2_clk_ena", {7'd0, bus.clk_ena}, (k >= 19 && k <= 27) ? 8'd0 : 8'd1);
    end

    // Move to 3, then lose lock -> flagged fallback to 0
    write(2'd3);
    tick(10);
    chk("s4_select3", {6'd0, bus.select}, 8'd3);
    bus.locked_in = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      tick(1);
      chk("s4_lock_ok", {7'd0, bus.lock_ok},   (k < 3) ? 8'd1 : 8'd0);
      chk("s4_lost",    {7'd0, bus.lock_lost}, (k >= 3) ? 8'd1 : 8'd0);
      chk("s4_select",  {6'd0, bus.select},    (k >= 9) ? 8'd0 : 8'd3);
      chk("s4_clk_ena", {7'd0, bus.clk_ena},   (k >= 4 && k <= 12) ? 8'd0 : 8'd1);
    end
    bus.lost_clr = 1'b1;
    tick(1);
    bus.lost_clr = 1'b0;
    chk("s4_clr", {7'd0, bus.lock_lost}, 8'd0);

    // Regain lock (req still 3), then clear coincident with a new loss: set wins
    bus.locked_in = 1'b1;
    tick(30);
    chk("s4_reselect3", {6'd0, bus.select}, 8'd3);
    bus.locked_in = 1'b0;
    tick(2);
    bus.lost_clr = 1'b1;
    tick(1);
    chk("s4_setclr_lock_ok", {7'd0, bus.lock_ok},   8'd0);
    chk("s4_setclr_lost",    {7'd0, bus.lock_lost}, 8'd1);
    tick(1);
    chk("s4_clr_alone", {7'd0, bus.lock_lost}, 8'd0);
    bus.lost_clr = 1'b0;
    tick(12);
    chk("s4_fallback", {6'd0, bus.select}, 8'd0);

    // Writing the current select value starts nothing
    write(2'd0);
    tick(1);
    chk("s5_same_busy", {7'd0, bus.busy}, 8'd0);
    bus.locked_in = 1'b1;
    tick(20);
    chk("s5_lock_ok", {7'd0, bus.lock_ok}, 8'd1);

    // Request changed during GATE_OFF: one sequence straight to 3
    write(2'd1);
    tick(2);
    write(2'd3);
    for (int k = 4; k <= 12; k++) begin
      tick(1);
      chk("s5_select",  {6'd0, bus.select},  (k >= 6) ? 8'd3 : 8'd0);
      chk("s5_clk_ena", {7'd0, bus.clk_ena}, (k >= 10) ? 8'd1 : 8'd0);
      chk("s5_busy",    {7'd0, bus.busy},    (k < 10) ? 8'd1 : 8'd0);
    end

    // Request changed during GATE_ON: one-cycle enable gap, then second sequence
    write(2'd1);
    tick(7);
    write(2'd2);
    for (int k = 9; k <= 21; k++) begin
      tick(1);
      chk("s5b_select",  {6'd0, bus.select},  (k >= 16) ? 8'd2 : 8'd1);
      chk("s5b_clk_ena", {7'd0, bus.clk_ena}, (k == 10 || k >= 20) ? 8'd1 : 8'd0);
      chk("s5b_busy",    {7'd0, bus.busy},    (k == 10 || k >= 20) ? 8'd0 : 8'd1);
    end

    // Reset during SWITCH
    write(2'd3);
    tick(5);
    chk("s6_pre_busy",   {7'd0, bus.busy},   8'd1);
    chk("s6_pre_select", {6'd0, bus.select}, 8'd2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("s6_select",  {6'd0, bus.select},  8'd0);
    chk("s6_clk_ena", {7'd0, bus.clk_ena}, 8'd1);
    chk("s6_busy",    {7'd0, bus.busy},    8'd0);
    chk("s6_req",     {6'd0, bus.req},     8'd0);

    // Randomized phase against the model
    run = 1;
    for (int c = 0; c < 3000; c++) begin
      bus.wr = ($urandom_range(0, 7) == 0);
      bus.wr_data = 2'($urandom_range(0, 3));
      bus.lost_clr = ($urandom_range(0, 15) == 0);
      run--;
      if (run <= 0) begin
        bus.locked_in = ~bus.locked_in;
        run = $urandom_range(1, 40);
      end
      rst = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    rst = 1'b0;
    bus.wr = 1'b0;
    bus.lost_clr = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lp805x_clksel_ctrl.md
Name: lp805x_clksel_ctrl

Overview:
- Clock-source sequencer sitting directly upstream of the lp805x_clkctrl mux; drives its clkselect and ena inputs.
- Takes a 2-bit source request from an SFR write and qualifies PLL sources (select 2/3) against a synchronized, debounced PLL locked signal.
- Glitch-safe switch: gates the mux output, changes select, then re-enables it.
- Falls back to select 0 (raw inclk0) on lock loss and flags the event for software.

Parameters:
LOCK_STABLE, 16, consecutive synchronized-locked cycles required before lock_ok asserts (1..255)
GATE_CYC, 4, cycles clk_ena is held low before and after a select change (1..255)
CNT_W, 8, width of the internal lock and gate counters

Ports:
clk  in  1  block clock (always-running reference)
rst  in  1  synchronous reset, active-high
wr  in  1  request write strobe
wr_data  in  2  requested source: 0/1 = inclk0, 2 = PLL c1, 3 = PLL c2
locked_in  in  1  PLL locked, asynchronous to clk
lost_clr  in  1  clears lock_lost
select  out  2  to clkctrl clkselect
clk_ena  out  1  to clkctrl ena
busy  out  1  switch sequence in progress
req  out  2  last written request (status readback)
lock_ok  out  1  debounced lock status
lock_lost  out  1  sticky: lock dropped while select[1]=1

Behaviour:
- Reset values:
  - select=0, req=0, clk_ena=1, busy=0, lock_ok=0, lock_lost=0.
  - Synchronizer flops = 0, counters = 0, state = RUN.
- Lock tracker:
  - 2-flop synchronizer feeds cnt; cnt increments while the synchronized value is 1, saturating at LOCK_STABLE, and clears when it is 0.
  - lock_ok = (cnt == LOCK_STABLE).
  - Timing, counting locked_in's edge-1 sample as the first edge: lock_ok rises at edge LOCK_STABLE+2 after locked_in rises, and falls at edge 3 after locked_in falls.
  - Glitches shorter than LOCK_STABLE cycles never assert lock_ok.
- Request:
  - req <= wr_data on every wr, in any state; last write wins, and there is no back-pressure.
  - target = (req[1] & ~lock_ok) ? 0 : req.
- FSM states: RUN, GATE_OFF, SWITCH, GATE_ON.
  - RUN: clk_ena=1, busy=0. If target != select, go to GATE_OFF (clk_ena<=0, gcnt<=0).
  - GATE_OFF: runs GATE_CYC cycles, then SWITCH.
  - SWITCH: one cycle; on exit, select<=target (target re-evaluated at that edge), gcnt<=0, go to GATE_ON.
  - GATE_ON: runs GATE_CYC cycles, then clk_ena<=1, go to RUN.
  - busy = (state != RUN), decoded combinationally.
  - If target still differs from select back in RUN (request changed mid-sequence), a new sequence starts next edge; clk_ena is high for exactly one cycle between sequences.
- Latency, from the wr edge (GATE_CYC=4):
  - state=GATE_OFF and clk_ena=0 at edge+1.
  - select updated at edge+6.
  - clk_ena=1 and RUN at edge+10.
  - General form: select changes at GATE_CYC+2; clk_ena returns at 2*GATE_CYC+2.
- Writing the current value of select: no sequence, busy stays 0.
- Request for 2/3 while lock_ok=0: target=0, so select stays 0 with no sequence. The switch starts on the first cycle after lock_ok rises.
- Lock loss while select[1]=1:
  - lock_lost<=1 on the edge where lock_ok falls.
  - target becomes 0, so a fallback sequence starts automatically.
  - If lock loss occurs mid-sequence, SWITCH picks up the new target.
- lock_lost clear: lost_clr clears it; a set and a clear in the same cycle resolve to set.
- rst mid-sequence: everything returns to reset values on the next edge, including select=0 and clk_ena=1.

Test Plan:
1. Reset, hold locked_in=0, wr 1 -> select 0->1 at wr+6, clk_ena low over wr+1..wr+9, busy high over the same window.
2. locked_in=0, wr 2 -> select stays 0, busy=0. Then raise locked_in -> lock_ok at +18; sequence starts next edge; select=2 six cycles later; clk_ena=1 four cycles after that.
3. locked_in pulse of 10 cycles -> lock_ok never asserts, select stays 0.
4. Running on select=3, drop locked_in -> lock_ok falls at +3, lock_lost=1, select=0 after the GATE_CYC+2 sequence. Assert lost_clr together with a fresh loss event -> lock_lost stays 1. Assert lost_clr alone -> lock_lost=0.
5. wr 1, then wr 3 (lock_ok=1) during GATE_OFF -> SWITCH loads 3 directly, only one sequence runs. wr 2 during GATE_ON -> clk_ena high for exactly 1 cycle, then a second sequence to 2.
6. Assert rst in the SWITCH cycle -> next edge: select=0, clk_ena=1, busy=0, req=0.
